alu_issue_stage: RTL and testbench

Execute-issue stage sitting directly upstream of the basic ALU.
- Accepts decoded RV32I integer instructions plus register operands from decode.
- Translates opcode/funct fields into the ALU's 4-bit op code and selects operands A/B.
- Presents the result through a registered two-entry skid buffer with valid/ready handshakes on both sides, so the ALU input is glitch-free and back-pressure does not create a combinational ready path.

---
 rtl/alu_issue_stage.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I integer ops into ALU op/operands and feeds them through a two-entry skid buffer.
// Latency: 1 cycle from accept (in EMPTY) to out_valid; one beat per cycle while out_ready=1.
// Backpressure: in_ready is a flop that drops the cycle after the second beat is buffered; no combinational in->out path.
// Optional feature: define ALU_ISSUE_SLT_SIGNED_EN to support SLT/SLTI via MSB-flipped operands on the unsigned LESS op.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [4:0]      rd_out,
    output logic            illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_LESS = 4'b1000;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    // Decoded payload; this (not the raw instruction fields) is what the buffer holds.
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic [4:0]      rd;
        logic            illegal;
    } beat_t;

    localparam beat_t BEAT_RESET = '{a: '0, b: '0, op: OP_ADD, rd: 5'd0, illegal: 1'b0};

    beat_t      dec;
    beat_t      out_q;
    beat_t      skid_q;
    logic [1:0] state_q;
    logic [1:0] state_nxt;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       accept;
    logic       drain;

    logic       dec_ok;
    logic [3:0] dec_op;
    logic       dec_use_imm;
    logic       dec_zero_a;
    logic       dec_signed;

    // Translate opcode/funct fields into ALU op and operand selection.
    always_comb begin
        dec_ok      = 1'b1;
        dec_op      = OP_ADD;
        dec_use_imm = 1'b0;
        dec_zero_a  = 1'b0;
        dec_signed  = 1'b0;
        case (opcode)
            OPC_R, OPC_I: begin
                dec_use_imm = (opcode == OPC_I);
                case (funct3)
                    3'b000: dec_op = (opcode == OPC_R && funct7_5) ? OP_SUB : OP_ADD;
                    3'b111: dec_op = OP_AND;
                    3'b110: dec_op = OP_OR;
                    3'b011: dec_op = OP_LESS;
`ifdef ALU_ISSUE_SLT_SIGNED_EN
                    3'b010: begin
                        dec_op     = OP_LESS;
                        dec_signed = 1'b1;
                    end
`else
                    3'b010: dec_ok = 1'b0;
`endif
                    default: dec_ok = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec_use_imm = 1'b1;
                dec_zero_a  = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Assemble the payload; illegal beats carry zeroed operands and rd.
    always_comb begin
        dec = BEAT_RESET;
        if (dec_ok) begin
            dec.a       = dec_zero_a ? '0 : rs1_data;
            dec.b       = dec_use_imm ? imm : rs2_data;
            dec.op      = dec_op;
            dec.rd      = rd_in;
            dec.illegal = 1'b0;
            // Flipping the sign bit turns a signed compare into an unsigned one.
            if (dec_signed) begin
                dec.a[XLEN-1] = ~dec.a[XLEN-1];
                dec.b[XLEN-1] = ~dec.b[XLEN-1];
            end
        end else begin
            dec.illegal = 1'b1;
        end
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Next buffer occupancy; flush wins over accept and drain.
    always_comb begin
        state_nxt = state_q;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_nxt = ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_nxt = ST_TWO;
                    else if (!accept && drain) state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (drain) state_nxt = ST_ONE;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Occupancy and handshake flops; ready/valid are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            in_ready_q  <= (state_nxt != ST_TWO);
            out_valid_q <= (state_nxt != ST_EMPTY);
        end
    end

    // Payload movement: output register holds the head, skid holds the second beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= BEAT_RESET;
            skid_q <= BEAT_RESET;
        end else if (!flush) begin
            case (state_q)
                ST_EMPTY: if (accept) out_q <= dec;
                ST_ONE: begin
                    if (accept && drain)       out_q  <= dec;
                    else if (accept && !drain) skid_q <= dec;
                end
                ST_TWO:   if (drain) out_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_a     = out_q.a;
    assign alu_b     = out_q.b;
    assign alu_op    = out_q.op;
    assign rd_out    = out_q.rd;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed + randomised bench for alu_issue_stage with a scoreboard queue of expected ALU beats.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd_out;
    logic        illegal;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd_out(rd_out), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the instruction-set view.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] im, input logic [4:0] rd);
        exp_t e;
        logic hit;
        logic sgn;
        logic [3:0] op;
        hit = 1'b1;
        sgn = 1'b0;
        op  = 4'b0010;
        e.a = r1;
        e.b = (opc == 7'b0110011) ? r2 : im;
        if (opc == 7'b0110111) begin
            e.a = 32'd0;
        end else if (opc == 7'b0110011 || opc == 7'b0010011) begin
            if (f3 == 3'b000)      op = (opc == 7'b0110011 && f75) ? 4'b0100 : 4'b0010;
            else if (f3 == 3'b111) op = 4'b0000;
            else if (f3 == 3'b110) op = 4'b0001;
            else if (f3 == 3'b011) op = 4'b1000;
`ifdef ALU_ISSUE_SLT_SIGNED_EN
            else if (f3 == 3'b010) begin op = 4'b1000; sgn = 1'b1; end
`endif
            else hit = 1'b0;
        end else begin
            hit = 1'b0;
        end
        if (sgn) begin
            e.a = e.a ^ 32'h8000_0000;
            e.b = e.b ^ 32'h8000_0000;
        end
        if (hit) begin
            e.op  = op;
            e.rd  = rd;
            e.ill = 1'b0;
        end else begin
            e = '{a: 32'd0, b: 32'd0, op: 4'b0010, rd: 5'd0, ill: 1'b1};
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [4:0] rd);
        in_valid = v; opcode = opc; funct3 = f3; funct7_5 = f75;
        rs1_data = r1; rs2_data = r2; imm = im; rd_in = rd;
    endtask

    // One clock: sample at negedge, score drains, record accepts, return #1 after posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL spurious_beat observed=beat op=%b rd=%0d expected=no beat", alu_op, rd_out);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("beat_a", alu_a, e.a);
                chk("beat_b", alu_b, e.b);
                chk("beat_op", {28'd0, alu_op}, {28'd0, e.op});
                chk("beat_rd", {27'd0, rd_out}, {27'd0, e.rd});
                chk("beat_illegal", {31'd0, illegal}, {31'd0, e.ill});
            end
        end
        last_acc = in_valid && in_ready && !flush;
        if (flush) q.delete();
        else if (last_acc) q.push_back(model(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, rd_in));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd2);
        chk({tag, "_rd_out"}, {27'd0, rd_out}, 32'd0);
        chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    logic [6:0] t_opc [12] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h13, 7'h37, 7'h03, 7'h33};
    logic [2:0] t_f3  [12] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd3, 3'd0, 3'd7, 3'd6, 3'd3, 3'd0, 3'd2, 3'd2};
    logic       t_f75 [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic drive_random();
        int k;
        k = $urandom_range(0, 11);
        drive(1'b1, t_opc[k], t_f3[k], t_f75[k], $urandom, $urandom, $urandom, 5'($urandom_range(1, 31)));
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
        #12;
        check_reset_values("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // SUB with downstream ready: visible one cycle after accept
        out_ready = 1'b1;
        drive(1'b1, 7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 5'd5);
        cyc();
        in_valid = 1'b0;
        chk("sub_latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("sub_alu_op", {28'd0, alu_op}, 32'b0100);
        cyc();
        cyc();
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // ANDI then ORI while stalled: skid fills, in_ready drops, order preserved
        out_ready = 1'b0;
        drive(1'b1, 7'b0010011, 3'b111, 1'b0, 32'hF0F0_1234, 32'd0, 32'h0000_00FF, 5'd7);
        cyc();
        chk("one_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 7'b0010011, 3'b110, 1'b0, 32'h0000_1000, 32'd0, 32'h0000_0F0F, 5'd8);
        cyc();
        in_valid = 1'b0;
        chk("two_in_ready", {31'd0, in_ready}, 32'd0);
        chk("two_head_op_stable", {28'd0, alu_op}, 32'b0000);
        cyc();
        chk("stall_head_a_stable", alu_a, 32'hF0F0_1234);
        out_ready = 1'b1;
        cyc();
        chk("drain1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("drain1_next_op", {28'd0, alu_op}, 32'b0001);
        cyc();
        chk("drain_all_queue", q.size(), 32'd0);

        // LUI, illegal load opcode and SLT back-to-back at full rate
        drive(1'b1, 7'b0110111, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 5'd9);
        cyc();
        drive(1'b1, 7'b0000011, 3'b010, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd10);
        cyc();
        drive(1'b1, 7'b0110011, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd11);
        cyc();
        in_valid = 1'b0;
`ifdef ALU_ISSUE_SLT_SIGNED_EN
        chk("slt_alu_a", alu_a, 32'h7FFF_FFFF);
        chk("slt_alu_b", alu_b, 32'h8000_0001);
`else
        chk("slt_illegal", {31'd0, illegal}, 32'd1);
`endif
        cyc();
        cyc();

        // Flush in TWO with a beat offered: nothing buffered or offered is emitted
        out_ready = 1'b0;
        drive(1'b1, 7'b0010011, 3'b000, 1'b0, 32'd1, 32'd0, 32'd2, 5'd1);
        cyc();
        drive(1'b1, 7'b0010011, 3'b000, 1'b0, 32'd3, 32'd0, 32'd4, 5'd2);
        cyc();
        drive(1'b1, 7'b0010011, 3'b000, 1'b0, 32'd5, 32'd0, 32'd6, 5'd3);
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_two_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_two_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Flush in ONE with an acceptable beat offered: that beat is discarded too
        out_ready = 1'b0;
        drive(1'b1, 7'b0110011, 3'b111, 1'b0, 32'd7, 32'd8, 32'd0, 5'd4);
        cyc();
        drive(1'b1, 7'b0110011, 3'b110, 1'b0, 32'd9, 32'd10, 32'd0, 5'd6);
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_one_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Full-throughput stream: in_ready never drops with out_ready held high
        for (int i = 0; i < 8; i++) begin
            drive_random();
            cyc();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        repeat (2) cyc();

        // Random backpressure, upstream holds each beat until accepted
        for (int i = 0; i < 40; i++) begin
            drive_random();
            guard = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                cyc();
                guard++;
            end while (!last_acc && guard < 50);
            chk("rand_accept_timeout", {31'd0, last_acc}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            cyc();
            guard++;
        end
        chk("rand_drain_queue", q.size(), 32'd0);

        // Asynchronous reset mid-transfer with out_valid high
        out_ready = 1'b0;
        drive(1'b1, 7'b0110011, 3'b000, 1'b1, 32'd100, 32'd1, 32'd0, 5'd12);
        cyc();
        in_valid = 1'b0;
        chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
